wb_slave_register: RTL and testbench
====================================

Name: wb_slave_register

Overview:
- Wishbone B4 slave containing a small bank of read/write data registers.
- Supports classic single read/write, read-modify-write and pipelined single read/write cycles with byte-lane selects.
- Sits behind a Wishbone interconnect as a generic control/status register block; out-of-range accesses are terminated with ERR.

Parameters:
- ADDR_WIDTH, 16, width of adr_i (byte address).
- DATA_WIDTH, 32, data bus width; must be a multiple of GRANULE.
- GRANULE, 8, bits per select lane; SEL_WIDTH = DATA_WIDTH/GRANULE.
- NUM_REGS, 8, number of DATA_WIDTH-wide registers; power of two, at least 1.

Ports:
- clk_i  in  1  single clock; all logic is on its rising edge.
- rst_i  in  1  synchronous, active-low reset.
- adr_i  in  ADDR_WIDTH  byte address.
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  read data.
- sel_i  in  SEL_WIDTH  lane selects.
- we_i  in  1  1 = write, 0 = read.
- cyc_i  in  1  bus cycle active.
- stb_i  in  1  strobe.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.

Behaviour:
- Reset (rst_i = 0 at a rising edge):
  - All registers, dat_o, ack_o and err_o are cleared to 0.
  - Any pending response is discarded.
- Word index: adr_i >> log2(SEL_WIDTH). Low address bits are ignored.
- Request acceptance: a request is accepted at a rising edge when cyc_i = 1, stb_i = 1, and ack_o = 0 and err_o = 0.
  - The ack/err qualification prevents a classic master that holds stb_i through the ack cycle from being serviced twice.
- Latency: the response (ack_o or err_o) is asserted for exactly one cycle, in the cycle after acceptance. ack_o and err_o are never asserted together.
- Error condition: err_o is returned instead of ack_o if the word index >= NUM_REGS or sel_i == 0. An errored write modifies nothing, and dat_o is 0.
- Write (we_i = 1):
  - The register is updated at the acceptance edge.
  - For each lane k with sel_i[k] = 1, bits [k*GRANULE +: GRANULE] take dat_i; unselected lanes keep their value.
- Read (we_i = 0):
  - dat_o is registered at the acceptance edge and valid while ack_o = 1.
  - Selected lanes carry register data; unselected lanes read as 0.
  - dat_o holds its value until the next accepted read.
  - A write response leaves dat_o unchanged.
- Classic cycles: the master holds stb_i until ack/err; response arrives 1 cycle after stb_i rises.
- Pipelined cycles: stb_i is high for 1 cycle only. The slave never stalls, so the response follows 1 cycle later. adr_i, dat_i and sel_i are don't-care (may be X) after acceptance.
- Read-modify-write:
  - Read phase, then write phase, within one cyc_i.
  - Each phase is an independent request and receives its own response.
- cyc_i dropped while a response is due: that response is suppressed (ack_o/err_o stay 0). A write already accepted remains committed.
- Back-to-back: a new request may be accepted in the cycle after a response completes, giving a maximum of one transfer per 2 cycles.
- Reset takes priority over any simultaneous request.

Optional Feature:
- Macro: WB_SLAVE_REGISTER_STALL_EN.
- When defined:
  - Adds output stall_o (1 bit).
  - stall_o = 1 while a response is pending (the cycle in which ack_o or err_o is asserted) or during reset.
  - stall_o = 0 otherwise.
  - A pipelined master must hold stb_i while stall_o = 1; acceptance additionally requires stall_o = 0.
- When undefined: no stall_o port; behaviour is exactly as described above.

Test Plan:
- Reset, then classic read of adr 0x0000, sel 0xF -> ack_o 1 cycle after stb_i; data 0x00000000.
- Classic write of 0xDEADBEEF to 0x0004 with sel 0xF, then classic read of 0x0004 with sel 0xF -> both ACK; read returns 0xDEADBEEF.
- Classic write of 0x11223344 to 0x0004 with sel 0x3; read with sel 0xF -> 0xDEAD3344. Read with sel 0xC -> 0xDEAD0000.
- Read-modify-write on 0x0008 (previously holding 0x12345678), writing 0xCAFEF00D -> read phase ACK with 0x12345678, write phase ACK; a later pipelined read returns 0xCAFEF00D.
- Pipelined write of 0xA5A5A5A5 to 0x001C, then pipelined read of 0x001C -> each gives ACK exactly 1 cycle after the single-cycle stb_i; data 0xA5A5A5A5.
- Classic read and write of 0x0020 (index 8 >= NUM_REGS), and any access with sel 0x0 -> err_o for 1 cycle, ack_o stays 0, registers unchanged.

Source files
------------

// File: rtl/wb_slave_register.sv
// Wishbone B4 slave with a small bank of byte-lane-writable registers.
// Define WB_SLAVE_REGISTER_STALL_EN to add the stall_o output.
module wb_slave_register #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int GRANULE    = 8,
   parameter int NUM_REGS   = 8
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [ADDR_WIDTH-1:0]             adr_i,
   input  logic [DATA_WIDTH-1:0]             dat_i,
   output logic [DATA_WIDTH-1:0]             dat_o,
   input  logic [(DATA_WIDTH/GRANULE)-1:0]   sel_i,
   input  logic                              we_i,
   input  logic                              cyc_i,
   input  logic                              stb_i,
   output logic                              ack_o,
`ifdef WB_SLAVE_REGISTER_STALL_EN
   output logic                              stall_o,
`endif
   output logic                              err_o
);

   localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
   localparam int LSB       = $clog2(SEL_WIDTH);
   localparam int IDXW      = ADDR_WIDTH - LSB;
   localparam int RIDX      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [IDXW-1:0]       widx;
   logic [RIDX-1:0]       ridx;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  ack_q;
   logic                  err_q;
   logic                  busy;
   logic                  hit;
   logic                  accept;

   assign widx = adr_i[ADDR_WIDTH-1:LSB];
   assign ridx = widx[RIDX-1:0];
   assign hit  = (32'(widx) < 32'(NUM_REGS)) && (sel_i != '0);
   assign busy = ack_q | err_q;

`ifdef WB_SLAVE_REGISTER_STALL_EN
   assign stall_o = busy | ~rst_i;
   assign accept  = cyc_i & stb_i & ~stall_o;
`else
   assign accept  = cyc_i & stb_i & ~busy;
`endif

   // A master that drops cyc_i abandons its pending response.
   assign ack_o = ack_q & cyc_i;
   assign err_o = err_q & cyc_i;

   generate
      if (LSB > 0) begin : g_lsb
         logic unused_lsb;
         assign unused_lsb = ^adr_i[LSB-1:0];
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < SEL_WIDTH; k++) begin
         if (sel_i[k]) begin
            rd_data[k*GRANULE +: GRANULE] = regs[ridx][k*GRANULE +: GRANULE];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_o <= '0;
      end else begin
         ack_q <= accept & hit;
         err_q <= accept & ~hit;
         if (accept && hit && we_i) begin
            for (int k = 0; k < SEL_WIDTH; k++) begin
               if (sel_i[k]) begin
                  regs[ridx][k*GRANULE +: GRANULE] <= dat_i[k*GRANULE +: GRANULE];
               end
            end
         end
         if (accept && !we_i) begin
            dat_o <= hit ? rd_data : '0;
         end
      end
   end

endmodule

// File: tb/tb_wb_slave_register.sv
// Directed self-checking bench for wb_slave_register.
// Classic vectors from a table, plus pipelined, RMW, cyc-drop and reset sequences.
module tb_wb_slave_register;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [15:0] adr_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic [3:0]  sel_i;
   logic        we_i;
   logic        cyc_i;
   logic        stb_i;
   logic        ack_o;
   logic        err_o;
`ifdef WB_SLAVE_REGISTER_STALL_EN
   logic        stall_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   wb_slave_register dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .adr_i   (adr_i),
      .dat_i   (dat_i),
      .dat_o   (dat_o),
      .sel_i   (sel_i),
      .we_i    (we_i),
      .cyc_i   (cyc_i),
      .stb_i   (stb_i),
      .ack_o   (ack_o),
`ifdef WB_SLAVE_REGISTER_STALL_EN
      .stall_o (stall_o),
`endif
      .err_o   (err_o)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [15:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        ack;
      logic        err;
      logic        chk_dat;
      logic [31:0] rdat;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      cyc_i = 1'b0;
      stb_i = 1'b0;
      we_i  = 1'b0;
      adr_i = 'x;
      dat_i = 'x;
      sel_i = 'x;
   endtask

   task automatic classic(input vec_t v);
      @(posedge clk_i); #1;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = v.we;
      adr_i = v.adr;
      dat_i = v.dat;
      sel_i = v.sel;
      @(posedge clk_i); #1;
      chk({v.name, " ack"}, 32'(ack_o), 32'(v.ack));
      chk({v.name, " err"}, 32'(err_o), 32'(v.err));
      if (v.chk_dat) chk({v.name, " dat"}, dat_o, v.rdat);
      @(posedge clk_i); #1;
      chk({v.name, " once"}, 32'({ack_o, err_o}), 32'(0));
      idle();
   endtask

   task automatic pipe(input string nm, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic cd, input logic [31:0] rd);
      @(posedge clk_i); #1;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = w;
      adr_i = a;
      dat_i = d;
      sel_i = 4'hF;
      @(posedge clk_i); #1;
      stb_i = 1'b0;
      adr_i = 'x;
      dat_i = 'x;
      sel_i = 'x;
      chk({nm, " ack"}, 32'(ack_o), 32'(1));
      chk({nm, " err"}, 32'(err_o), 32'(0));
      if (cd) chk({nm, " dat"}, dat_o, rd);
      @(posedge clk_i); #1;
      chk({nm, " once"}, 32'(ack_o), 32'(0));
      idle();
   endtask

   initial begin
      vecs[0]  = '{"rd0",      0, 16'h0000, 32'h0,        4'hF, 1, 0, 1, 32'h00000000};
      vecs[1]  = '{"wr4",      1, 16'h0004, 32'hDEADBEEF, 4'hF, 1, 0, 0, 32'h0};
      vecs[2]  = '{"rd4",      0, 16'h0004, 32'h0,        4'hF, 1, 0, 1, 32'hDEADBEEF};
      vecs[3]  = '{"wr4_s3",   1, 16'h0004, 32'h11223344, 4'h3, 1, 0, 0, 32'h0};
      vecs[4]  = '{"rd4_sF",   0, 16'h0004, 32'h0,        4'hF, 1, 0, 1, 32'hDEAD3344};
      vecs[5]  = '{"rd4_sC",   0, 16'h0004, 32'h0,        4'hC, 1, 0, 1, 32'hDEAD0000};
      vecs[6]  = '{"wr8",      1, 16'h0008, 32'h12345678, 4'hF, 1, 0, 0, 32'h0};
      vecs[7]  = '{"rd20_err", 0, 16'h0020, 32'h0,        4'hF, 0, 1, 1, 32'h00000000};
      vecs[8]  = '{"wr20_err", 1, 16'h0020, 32'hFFFFFFFF, 4'hF, 0, 1, 0, 32'h0};
      vecs[9]  = '{"wr_s0",    1, 16'h0004, 32'h00000000, 4'h0, 0, 1, 0, 32'h0};
      vecs[10] = '{"rd_s0",    0, 16'h0004, 32'h0,        4'h0, 0, 1, 1, 32'h00000000};
      vecs[11] = '{"rd4_keep", 0, 16'h0004, 32'h0,        4'hF, 1, 0, 1, 32'hDEAD3344};
      vecs[12] = '{"rd6_lsb",  0, 16'h0006, 32'h0,        4'h1, 1, 0, 1, 32'h00000044};

      idle();
      rst_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst ack", 32'(ack_o), 32'(0));
      chk("rst err", 32'(err_o), 32'(0));
      chk("rst dat", dat_o, 32'h0);
`ifdef WB_SLAVE_REGISTER_STALL_EN
      chk("rst stall", 32'(stall_o), 32'(1));
`endif
      rst_i = 1'b1;

      for (int i = 0; i < 13; i++) classic(vecs[i]);

      // read-modify-write on 0x0008 within one cyc_i
      @(posedge clk_i); #1;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = 1'b0;
      adr_i = 16'h0008;
      sel_i = 4'hF;
      @(posedge clk_i); #1;
      chk("rmw rd ack", 32'(ack_o), 32'(1));
      chk("rmw rd dat", dat_o, 32'h12345678);
      @(posedge clk_i); #1;
      chk("rmw gap", 32'(ack_o), 32'(0));
      we_i  = 1'b1;
      dat_i = 32'hCAFEF00D;
      @(posedge clk_i); #1;
      chk("rmw wr ack", 32'(ack_o), 32'(1));
      chk("rmw wr dat", dat_o, 32'h12345678);
      stb_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rmw end", 32'(ack_o), 32'(0));
      idle();

      pipe("p_rd8",  0, 16'h0008, 32'h0,        1, 32'hCAFEF00D);
      pipe("p_wr1c", 1, 16'h001C, 32'hA5A5A5A5, 0, 32'h0);
      pipe("p_rd1c", 0, 16'h001C, 32'h0,        1, 32'hA5A5A5A5);

      // cyc_i dropped with a response due: no ack, write still committed
      @(posedge clk_i); #1;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = 1'b1;
      adr_i = 16'h000C;
      dat_i = 32'h55AA55AA;
      sel_i = 4'hF;
      @(posedge clk_i); #1;
      idle();
      #1;
      chk("drop ack", 32'(ack_o), 32'(0));
      chk("drop err", 32'(err_o), 32'(0));
      @(posedge clk_i); #1;
      chk("drop late", 32'(ack_o), 32'(0));
      classic('{"rd_c", 0, 16'h000C, 32'h0, 4'hF, 1, 0, 1, 32'h55AA55AA});

      // reset beats a simultaneous request and clears registers
      @(posedge clk_i); #1;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = 1'b1;
      adr_i = 16'h0010;
      dat_i = 32'h77777777;
      sel_i = 4'hF;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rst2 ack", 32'(ack_o), 32'(0));
      chk("rst2 dat", dat_o, 32'h0);
      rst_i = 1'b1;
      idle();
      classic('{"rd4_rst", 0, 16'h0004, 32'h0, 4'hF, 1, 0, 1, 32'h00000000});
      classic('{"rd10_rst", 0, 16'h0010, 32'h0, 4'hF, 1, 0, 1, 32'h00000000});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
